// File: rtl/s2mm_pkg.sv
// Shared types for the S2MM decimating framer: run modes and controller states.
package s2mm_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_DECIM   = 2'd1,
    MODE_FRAMED  = 2'd2,
    MODE_DISCARD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DROP_W = 32;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream output register. Upstream may load whenever the
// entry is empty or is being drained in the same cycle, so a continuous
// stream passes at full rate with one cycle of latency.
module axis_reg_slice #(
  parameter int WIDTH = 32
) (
  input  logic               axis_aclk,
  input  logic               axis_aresetn,
  input  logic               in_valid_i,
  input  logic [WIDTH-1:0]   in_data_i,
  input  logic [WIDTH/8-1:0] in_keep_i,
  input  logic               in_last_i,
  output logic               in_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [WIDTH/8-1:0] out_keep_o,
  output logic               out_last_o
);

  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH/8-1:0] keep_q;
  logic               last_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;
  assign out_last_o  = last_q;

  // Load on an upstream push, otherwise empty once the consumer takes the beat;
  // payload is only written on a load so it stays stable while stalled.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      keep_q  <= in_keep_i;
      last_q  <= in_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/s2mm_decim_framer.sv
// Decimating / framing front end for a DMA S2MM channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not running; input accepted and thrown away, not counted
// ST_RUN   | config latched; beats decimated/framed and forwarded
// ST_DRAIN | en dropped mid-frame; keep decimating until the frame's tlast
//          | beat leaves on m_axis
import s2mm_pkg::*;

module s2mm_decim_framer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 26,
  parameter int LEN_W = 16
) (
  input  logic               axis_aclk,
  input  logic               axis_aresetn,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic [WIDTH/8-1:0] s_axis_tkeep,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [WIDTH-1:0]   m_axis_tdata,
  output logic [WIDTH/8-1:0] m_axis_tkeep,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   decim,
  input  logic [LEN_W-1:0]   pkt_len,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               busy
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [CNT_W-1:0]    decim_q, decim_d;
  logic [LEN_W-1:0]    pkt_len_q, pkt_len_d;
  logic [CNT_W-1:0]    phase_q, phase_d;
  logic [LEN_W-1:0]    frame_q, frame_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                active, slice_ready, run_hs, m_hs, frame_done;
  logic [CNT_W-1:0]    phase_cur, phase_nxt;
  logic [LEN_W-1:0]    pkt_last_idx;
  logic                keep, beat_last, push;

  assign active        = (state_q != ST_IDLE);
  assign busy          = active;
  assign drop_cnt      = drop_q;
  assign s_axis_tready = active ? slice_ready : 1'b1;
  assign run_hs        = s_axis_tvalid && s_axis_tready && active;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign pkt_last_idx  = (pkt_len_q == '0) ? '0 : pkt_len_q - LEN_W'(1);
  // In DRAIN the frame counter only returns to zero once the closing beat is issued.
  assign frame_done    = (state_q == ST_DRAIN) && (frame_q == '0);

  // Keep/drop decision for the beat currently offered on s_axis.
  always_comb begin
    // A tlast beat in decimate mode acts as the phase-0 beat of a new cadence.
    phase_cur = (mode_q == MODE_DECIM && s_axis_tlast) ? '0 : phase_q;
    phase_nxt = (decim_q <= CNT_W'(1) || phase_cur == decim_q - CNT_W'(1)) ?
                '0 : phase_cur + CNT_W'(1);
    keep      = 1'b0;
    beat_last = 1'b0;
    unique case (mode_q)
      MODE_BYPASS: begin
        keep      = 1'b1;
        beat_last = s_axis_tlast;
      end
      MODE_DECIM: begin
        keep      = (phase_cur == '0);
        beat_last = s_axis_tlast;
      end
      MODE_FRAMED: begin
        keep      = (phase_q == '0) && !frame_done;
        beat_last = (frame_q == pkt_last_idx);
      end
      default: begin
        keep      = 1'b0;
        beat_last = 1'b0;
      end
    endcase
    push = run_hs && keep;
  end

  // Next state, config latch and phase/frame/drop counters.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    decim_d   = decim_q;
    pkt_len_d = pkt_len_q;
    phase_d   = phase_q;
    frame_d   = frame_q;
    drop_d    = drop_q;
    if (run_hs) begin
      if (mode_q == MODE_DECIM || mode_q == MODE_FRAMED) phase_d = phase_nxt;
      if (mode_q == MODE_FRAMED && keep) frame_d = beat_last ? '0 : frame_q + LEN_W'(1);
      if (!keep && drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_RUN;
          mode_d    = mode_e'(mode);
          decim_d   = decim;
          pkt_len_d = pkt_len;
          phase_d   = '0;
          frame_d   = '0;
          drop_d    = '0;
        end
      end
      ST_RUN: begin
        // Look at the post-beat frame count so a beat closing the frame this
        // cycle does not leave us waiting in DRAIN for a frame that never starts.
        if (!en) state_d = (mode_q == MODE_FRAMED && frame_d != '0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (m_hs && m_axis_tlast && frame_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_BYPASS;
      decim_q   <= '0;
      pkt_len_q <= '0;
      phase_q   <= '0;
      frame_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      decim_q   <= decim_d;
      pkt_len_q <= pkt_len_d;
      phase_q   <= phase_d;
      frame_q   <= frame_d;
      drop_q    <= drop_d;
    end
  end

  axis_reg_slice #(.WIDTH(WIDTH)) u_out_reg (
    .axis_aclk   (axis_aclk),
    .axis_aresetn(axis_aresetn),
    .in_valid_i  (push),
    .in_data_i   (s_axis_tdata),
    .in_keep_i   (s_axis_tkeep),
    .in_last_i   (beat_last),
    .in_ready_o  (slice_ready),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready),
    .out_data_o  (m_axis_tdata),
    .out_keep_o  (m_axis_tkeep),
    .out_last_o  (m_axis_tlast)
  );

endmodule

// File: tb/tb_s2mm_decim_framer.sv
// Bench for s2mm_decim_framer: directed scenarios plus randomized runs
// checked against a beat-index reference model.
module tb_s2mm_decim_framer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 26;
  localparam int LEN_W = 16;
  localparam int KW    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_tvalid, s_tready, s_tlast;
  logic [WIDTH-1:0] s_tdata;
  logic [KW-1:0]    s_tkeep;
  logic             m_tvalid, m_tready, m_tlast;
  logic [WIDTH-1:0] m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             en;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_decim;
  logic [LEN_W-1:0] cfg_pkt;
  logic [31:0]      drop_cnt;
  logic             busy;

  int tests  = 0;
  int errors = 0;

  logic             rdy_rand = 1'b0;
  logic             rdy_hold = 1'b1;
  logic             hold_en  = 1'b1;
  logic             hold_pend = 1'b0;
  logic [WIDTH-1:0] hold_d;
  logic             hold_l;

  logic [WIDTH-1:0] in_d[$];
  logic [KW-1:0]    in_k[$];
  logic             in_l[$];
  logic [WIDTH-1:0] exp_d[$];
  logic [KW-1:0]    exp_k[$];
  logic             exp_l[$];
  int               exp_drop;
  logic [WIDTH-1:0] obs_d[$];
  logic [KW-1:0]    obs_k[$];
  logic             obs_l[$];

  s2mm_decim_framer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .en           (en),
    .mode         (cfg_mode),
    .decim        (cfg_decim),
    .pkt_len      (cfg_pkt),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Downstream ready: fixed level or a coin flip per cycle.
  always @(posedge clk) begin
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_hold;
  end

  // Output monitor: records a beat at the negedge before its handshake edge,
  // and checks that a stalled beat is still there, unchanged, one cycle later.
  always @(negedge clk) begin
    if (rst_n && hold_en && hold_pend) begin
      tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l) begin
        errors++;
        $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 m_tvalid, m_tdata, m_tlast, hold_d, hold_l);
      end
    end
    hold_pend = rst_n && m_tvalid && !m_tready;
    hold_d    = m_tdata;
    hold_l    = m_tlast;
    if (rst_n && m_tvalid && m_tready) begin
      obs_d.push_back(m_tdata);
      obs_k.push_back(m_tkeep);
      obs_l.push_back(m_tlast);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  task automatic clear_q();
    in_d.delete(); in_k.delete(); in_l.delete();
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    obs_d.delete(); obs_k.delete(); obs_l.delete();
    exp_drop = 0;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic [KW-1:0] k, input logic l);
    int guard;
    guard = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    @(negedge clk);
    while (!s_tready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      tests++; errors++;
      $display("FAIL send_timeout: s_axis_tready stuck at %b for beat %h, required 1", s_tready, d);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_all();
    for (int i = 0; i < in_d.size(); i++) send_beat(in_d[i], in_k[i], in_l[i]);
  endtask

  task automatic start_run(input logic [1:0] m, input int d, input int p);
    int guard;
    guard = 0;
    cfg_mode = m; cfg_decim = CNT_W'(d); cfg_pkt = LEN_W'(p); en = 1'b1;
    @(negedge clk);
    while (!busy && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      tests++; errors++;
      $display("FAIL start_timeout: busy=%b, required 1", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic stop_run();
    int guard;
    guard = 0;
    en = 1'b0;
    @(negedge clk);
    while (busy && guard < 2000) begin @(negedge clk); guard++; end
    if (guard >= 2000) begin
      tests++; errors++;
      $display("FAIL stop_timeout: busy=%b, required 0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic flush(input int n);
    int guard;
    guard = 0;
    while (obs_d.size() < n && guard < 3000) begin @(posedge clk); guard++; end
    if (guard >= 3000) begin
      tests++; errors++;
      $display("FAIL flush_timeout: %0d output beats seen, required %0d", obs_d.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference: decide each beat from its index alone.
  //  mode 1: kept if tlast, or its distance from the latest tlast beat (or
  //          from the run start) is a multiple of decim.
  //  mode 2: kept if index is a multiple of decim; every pkt_len-th kept beat
  //          closes a frame.
  task automatic build_expected(input int m, input int d, input int p);
    int de, pe, anchor, j;
    logic k, lst;
    de = (d <= 1) ? 1 : d;
    pe = (p == 0) ? 1 : p;
    anchor = 0; j = 0;
    for (int i = 0; i < in_d.size(); i++) begin
      k = 1'b0; lst = 1'b0;
      case (m)
        0: begin k = 1'b1; lst = in_l[i]; end
        1: begin
          if (in_l[i]) begin k = 1'b1; lst = 1'b1; anchor = i; end
          else k = ((i - anchor) % de == 0);
        end
        2: begin
          k = (i % de == 0);
          if (k) begin lst = ((j + 1) % pe == 0); j++; end
        end
        default: k = 1'b0;
      endcase
      if (k) begin
        exp_d.push_back(in_d[i]); exp_k.push_back(in_k[i]); exp_l.push_back(lst);
      end else exp_drop++;
    end
  endtask

  task automatic test_reset();
    #12;
    tests++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b, required 1", s_tready); end
    tests++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); end
    tests++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %b, required 0", m_tlast); end
    tests++; if (m_tdata !== '0 || m_tkeep !== '0) begin errors++; $display("FAIL reset_m_payload: got %h/%h, required 0/0", m_tdata, m_tkeep); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decim10();
    clear_q();
    start_run(2'd1, 10, 0);
    for (int i = 0; i < 40; i++) send_beat(WIDTH'(i), 4'hF, 1'b0);
    flush(4);
    tests++; if (obs_d.size() != 4) begin errors++; $display("FAIL decim10_count: got %0d beats, required 4", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 4; i++) begin
      tests++;
      if (obs_d[i] !== WIDTH'(i * 10) || obs_l[i] !== 1'b0) begin
        errors++; $display("FAIL decim10_beat%0d: got %0d last=%b, required %0d last=0", i, obs_d[i], obs_l[i], i * 10);
      end
    end
    tests++; if (drop_cnt !== 32'd36) begin errors++; $display("FAIL decim10_drop: got %0d, required 36", drop_cnt); end
    stop_run();
  endtask

  task automatic test_framed();
    logic [WIDTH-1:0] ed[6];
    logic             el[6];
    ed = '{0, 2, 4, 6, 8, 10};
    el = '{0, 0, 1, 0, 0, 1};
    clear_q();
    start_run(2'd2, 2, 3);
    for (int i = 0; i < 12; i++) send_beat(WIDTH'(i), 4'hF, 1'b0);
    flush(6);
    tests++; if (obs_d.size() != 6) begin errors++; $display("FAIL framed_count: got %0d beats, required 6", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 6; i++) begin
      tests++;
      if (obs_d[i] !== ed[i] || obs_l[i] !== el[i]) begin
        errors++; $display("FAIL framed_beat%0d: got %0d last=%b, required %0d last=%b", i, obs_d[i], obs_l[i], ed[i], el[i]);
      end
    end
    tests++; if (drop_cnt !== 32'd6) begin errors++; $display("FAIL framed_drop: got %0d, required 6", drop_cnt); end
    stop_run();
  endtask

  task automatic test_tlast_decim();
    logic [WIDTH-1:0] ed[4];
    logic             el[4];
    ed = '{0, 4, 5, 9};
    el = '{0, 0, 1, 0};
    clear_q();
    start_run(2'd1, 4, 0);
    for (int i = 0; i < 13; i++) send_beat(WIDTH'(i), 4'hF, (i == 5));
    flush(4);
    tests++; if (obs_d.size() != 4) begin errors++; $display("FAIL tlast_count: got %0d beats, required 4", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 4; i++) begin
      tests++;
      if (obs_d[i] !== ed[i] || obs_l[i] !== el[i]) begin
        errors++; $display("FAIL tlast_beat%0d: got %0d last=%b, required %0d last=%b", i, obs_d[i], obs_l[i], ed[i], el[i]);
      end
    end
    tests++; if (drop_cnt !== 32'd9) begin errors++; $display("FAIL tlast_drop: got %0d, required 9", drop_cnt); end
    stop_run();
  endtask

  task automatic test_drain();
    clear_q();
    start_run(2'd2, 1, 4);
    send_beat(32'd0, 4'hF, 1'b0);
    send_beat(32'd1, 4'hF, 1'b0);
    flush(2);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_hold: got %b, required 1", busy); end
    send_beat(32'd2, 4'hF, 1'b0);
    flush(3);
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_beat3: got %b, required 1", busy); end
    send_beat(32'd3, 4'hF, 1'b0);
    flush(4);
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_end: got %b, required 0", busy); end
    tests++; if (obs_d.size() != 4) begin errors++; $display("FAIL drain_count: got %0d beats, required 4", obs_d.size()); end
    for (int i = 0; i < obs_d.size() && i < 4; i++) begin
      tests++;
      if (obs_d[i] !== WIDTH'(i) || obs_l[i] !== (i == 3)) begin
        errors++; $display("FAIL drain_beat%0d: got %0d last=%b, required %0d last=%b", i, obs_d[i], obs_l[i], i, (i == 3));
      end
    end
  endtask

  task automatic test_random_bypass();
    clear_q();
    rdy_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_d.push_back($urandom); in_k.push_back(KW'($urandom_range(0, 15)));
      in_l.push_back($urandom_range(0, 7) == 0);
    end
    build_expected(0, 0, 0);
    start_run(2'd0, 0, 0);
    send_all();
    flush(exp_d.size());
    tests++; if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL bypass_count: got %0d beats, required %0d", obs_d.size(), exp_d.size()); end
    for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
      tests++;
      if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL bypass_beat%0d: got %h/%h/%b, required %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
      end
    end
    tests++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL bypass_drop: got %0d, required 0", drop_cnt); end
    stop_run();
    rdy_rand = 1'b0;
  endtask

  task automatic test_random_decim();
    int m, d, p, n;
    rdy_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      clear_q();
      m = (r % 2 == 0) ? 1 : 2;
      d = $urandom_range(0, 5);
      p = $urandom_range(0, 4);
      // framed runs end on a frame boundary so the run stops straight to IDLE
      n = (m == 1) ? 80 : ((d <= 1) ? 1 : d) * ((p == 0) ? 1 : p) * 3;
      for (int i = 0; i < n; i++) begin
        in_d.push_back($urandom); in_k.push_back(KW'($urandom_range(0, 15)));
        in_l.push_back($urandom_range(0, 9) == 0);
      end
      build_expected(m, d, p);
      start_run(2'(m), d, p);
      send_all();
      flush(exp_d.size());
      tests++; if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL rand%0d_count: got %0d beats, required %0d", r, obs_d.size(), exp_d.size()); end
      for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
        tests++;
        if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d: got %h/%h/%b, required %h/%h/%b", r, i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
        end
      end
      tests++; if (drop_cnt !== 32'(exp_drop)) begin errors++; $display("FAIL rand%0d_drop: got %0d, required %0d", r, drop_cnt, exp_drop); end
      stop_run();
    end
    rdy_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_q();
    hold_en  = 1'b0;
    rdy_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_run(2'd2, 1, 4);
    send_beat(32'hA5A5_0001, 4'hF, 1'b0);
    tests++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: m_tvalid=%b, required 1", m_tvalid); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b, required 0", m_tvalid); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_hold = 1'b1;
    obs_d.delete(); obs_k.delete(); obs_l.delete();
    repeat (10) @(posedge clk);
    #1;
    tests++; if (obs_d.size() != 0) begin errors++; $display("FAIL rstmid_no_output: got %0d beats, required 0", obs_d.size()); end
    tests++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_drop: got %0d, required 0", drop_cnt); end
    tests++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rstmid_s_tready: got %b, required 1", s_tready); end
    hold_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;
    m_tready = 1'b1;
    cfg_mode = 2'd0; cfg_decim = '0; cfg_pkt = '0;
    exp_drop = 0;
    test_reset();
    test_decim10();
    test_framed();
    test_tlast_decim();
    test_drain();
    test_random_bypass();
    test_random_decim();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
